mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL take parameter MAX_WAIT, default 255, the maximum number of cycles to wait for mem_ack; legal range 1..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port i_req, input, 1, instruction-fetch request; held high until i_ready.
REQ-005 SHALL have port i_addr, input, 32, fetch address (pcF).
REQ-006 SHALL have port i_rdata, output, 32, fetched instruction; valid while i_ready=1.
REQ-007 SHALL have port i_ready, output, 1, one-cycle fetch-complete pulse.
REQ-008 SHALL have ports d_req/d_we, input, 1 each: data request, held until d_ready; write enable (mem_writeM).
REQ-009 SHALL have ports d_addr/d_wdata, input, 32 each: alu_outM and write_dataM.
REQ-010 SHALL have ports d_rdata, output, 32, and d_ready, output, 1, with the same meaning as i_rdata/i_ready.
REQ-011 SHALL have ports mem_req/mem_we, output, 1 each, and mem_addr/mem_wdata, output, 32 each, forming the shared memory bus request.
REQ-012 SHALL have ports mem_rdata, input, 32, and mem_ack, input, 1, the memory response.
REQ-013 SHALL have port stall, output, 1, the pipeline freeze for the F/D/E/M registers.
REQ-014 SHALL have port bus_err, output, 1, sticky timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, I_WAIT, D_WAIT and RESP.
REQ-016 IDLE: d_req=1 SHALL transition to D_WAIT; otherwise i_req=1 SHALL transition to I_WAIT. Data has fixed priority over fetch.
REQ-017 On the grant edge SHALL register the address, we (0 for fetch) and wdata onto mem_*; mem_req SHALL go high the following cycle.
REQ-018 mem_addr, mem_we and mem_wdata SHALL stay stable while mem_req=1.
REQ-019 In *_WAIT, mem_ack=1 SHALL capture mem_rdata on that edge, drop mem_req and transition to RESP.
REQ-020 RESP SHALL assert exactly one ready (i_ready or d_ready, matching the grant) for one cycle, then go to IDLE; no grant is issued from RESP.
REQ-021 The i_rdata/d_rdata registers SHALL hold their last value until the next capture; for a write, d_rdata is don't-care.
REQ-022 stall SHALL be combinational: (i_req & ~i_ready) | (d_req & ~d_ready).
REQ-023 An 8-bit wait counter SHALL clear on grant and increment each *_WAIT cycle without ack.
REQ-024 When the counter reaches MAX_WAIT with mem_ack=0, the block SHALL drop mem_req, load rdata with 32'h0, set bus_err, and go to RESP.
REQ-025 If mem_ack=1 arrives in the same cycle as the timeout, the ack SHALL win and bus_err SHALL be unchanged.
REQ-026 mem_ack SHALL be ignored in IDLE and RESP.
REQ-027 bus_err SHALL be cleared only by reset.
REQ-028 Minimum access latency SHALL be: req sampled at edge k, mem_req high in cycle k+1, ack in cycle k+1, ready in cycle k+2.
REQ-029 Requests with i_req and d_req both high SHALL complete the data access first, followed by the fetch after one IDLE cycle.

Reset
REQ-030 On rst=0, the block SHALL immediately enter IDLE and drive mem_req, mem_we, i_ready, d_ready and bus_err to 0, mem_addr/mem_wdata/i_rdata/d_rdata to 32'h0, and the counter to 0.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction without a ready pulse; after release, still-held requests SHALL be re-arbitrated from IDLE.

Verification
REQ-032 Fetch i_addr=0x0000_0040, ack one cycle after mem_req with mem_rdata=0x2008_0005 -> i_ready for one cycle with i_rdata=0x2008_0005, mem_we=0, stall low in that cycle.
REQ-033 Simultaneous i_req and d_req (store, d_addr=0x0000_0050, d_wdata=0x0000_0007) -> write issued first with mem_we=1 and d_ready; the fetch is issued after one IDLE cycle.
REQ-034 With MAX_WAIT=4 and no ack -> mem_req drops after 4 wait cycles, ready pulses with rdata=0, bus_err=1 and stays 1.
REQ-035 mem_ack arriving together with the timeout -> normal completion with captured data, bus_err=0.
REQ-036 rst pulled low while in D_WAIT -> mem_req=0 immediately, no d_ready; after release, the held d_req is re-granted.
REQ-037 Spurious mem_ack in IDLE -> no state change and no ready pulse.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the data port and the shared memory bus seen by mem_arbiter.
// The master side is the pipeline plus memory; the slave side is the arbiter.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        bus_err;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr,
           mem_wdata, stall, bus_err
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr,
           mem_wdata, stall, bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one memory bus, data first,
// with a bounded wait for mem_ack and a sticky bus_err on timeout.
module mem_arbiter #(
  parameter int MAX_WAIT = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        is_data_q, is_data_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        bus_err_q, bus_err_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        waiting, timeout;

  assign waiting = (state_q == I_WAIT) || (state_q == D_WAIT);
  // The ack takes precedence when it lands in the last permitted wait cycle.
  assign timeout = waiting && !bus.mem_ack && ((wait_cnt_q + 8'd1) == MAX_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.d_req)      state_d = D_WAIT;
        else if (bus.i_req) state_d = I_WAIT;
      end
      I_WAIT, D_WAIT: begin
        if (bus.mem_ack || timeout) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.i_ready = (state_q == RESP) && !is_data_q;
    bus.d_ready = (state_q == RESP) &&  is_data_q;
  end

  always_comb begin
    is_data_d   = is_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    bus_err_d   = bus_err_q;
    wait_cnt_d  = wait_cnt_q;
    if (state_q == IDLE && (bus.d_req || bus.i_req)) begin
      is_data_d   = bus.d_req;
      mem_req_d   = 1'b1;
      mem_we_d    = bus.d_req && bus.d_we;
      mem_addr_d  = bus.d_req ? bus.d_addr  : bus.i_addr;
      mem_wdata_d = bus.d_req ? bus.d_wdata : 32'h0;
      wait_cnt_d  = 8'd0;
    end else if (waiting) begin
      if (bus.mem_ack) begin
        mem_req_d = 1'b0;
        if (is_data_q) d_rdata_d = bus.mem_rdata;
        else           i_rdata_d = bus.mem_rdata;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (timeout) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (is_data_q) d_rdata_d = 32'h0;
          else           i_rdata_d = 32'h0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_data_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      i_rdata_q   <= 32'h0;
      d_rdata_q   <= 32'h0;
      bus_err_q   <= 1'b0;
      wait_cnt_q  <= 8'd0;
    end else begin
      is_data_q   <= is_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.stall     = (bus.i_req && !bus.i_ready) || (bus.d_req && !bus.d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MAX_WAIT=4: fetch, data priority, timeout,
// ack-at-timeout, spurious ack and mid-transaction reset.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Returns 1ns after the next rising edge, i.e. early in the following cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] dwd);
    bus.i_req   = ir;
    bus.i_addr  = ia;
    bus.d_req   = dr;
    bus.d_we    = dw;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
  endtask

  initial begin
    rst = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    #3;
    check_output("rst_mem_req", bus.mem_req, 32'h0);
    check_output("rst_bus_err", bus.bus_err, 32'h0);
    check_output("rst_readies", {bus.i_ready, bus.d_ready}, 32'h0);
    check_output("rst_mem_addr", bus.mem_addr, 32'h0);
    check_output("rst_i_rdata", bus.i_rdata, 32'h0);
    check_output("rst_stall", bus.stall, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Single fetch with minimum latency
    apply_stimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_output("f_stall_pending", bus.stall, 32'h1);
    tick();
    check_output("f_mem_req", bus.mem_req, 32'h1);
    check_output("f_mem_addr", bus.mem_addr, 32'h0000_0040);
    check_output("f_mem_we", bus.mem_we, 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h2008_0005;
    tick();
    bus.mem_ack = 1'b0;
    check_output("f_i_ready", bus.i_ready, 32'h1);
    check_output("f_d_ready", bus.d_ready, 32'h0);
    check_output("f_i_rdata", bus.i_rdata, 32'h2008_0005);
    check_output("f_mem_req_drop", bus.mem_req, 32'h0);
    check_output("f_stall_low", bus.stall, 32'h0);
    bus.i_req = 1'b0;
    tick();
    check_output("f_i_ready_pulse", bus.i_ready, 32'h0);
    check_output("f_i_rdata_hold", bus.i_rdata, 32'h2008_0005);

    // Simultaneous store and fetch: data first, fetch after one IDLE cycle
    apply_stimulus(1'b1, 32'h0000_0044, 1'b1, 1'b1, 32'h0000_0050, 32'h0000_0007);
    tick();
    check_output("p_mem_req", bus.mem_req, 32'h1);
    check_output("p_mem_we", bus.mem_we, 32'h1);
    check_output("p_mem_addr", bus.mem_addr, 32'h0000_0050);
    check_output("p_mem_wdata", bus.mem_wdata, 32'h0000_0007);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_ack = 1'b0;
    check_output("p_d_ready", bus.d_ready, 32'h1);
    check_output("p_i_ready", bus.i_ready, 32'h0);
    check_output("p_stall_fetch", bus.stall, 32'h1);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick();
    check_output("p_idle_mem_req", bus.mem_req, 32'h0);
    check_output("p_idle_readies", {bus.i_ready, bus.d_ready}, 32'h0);
    tick();
    check_output("p_f_mem_req", bus.mem_req, 32'h1);
    check_output("p_f_mem_addr", bus.mem_addr, 32'h0000_0044);
    check_output("p_f_mem_we", bus.mem_we, 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    tick();
    bus.mem_ack = 1'b0;
    check_output("p_f_i_ready", bus.i_ready, 32'h1);
    check_output("p_f_i_rdata", bus.i_rdata, 32'h1111_2222);
    bus.i_req = 1'b0;
    tick();

    // Ack arriving in the last permitted wait cycle wins over the timeout
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_output("a_mem_req_held", bus.mem_req, 32'h1);
      tick();
    end
    check_output("a_mem_req_last", bus.mem_req, 32'h1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    bus.mem_ack = 1'b0;
    check_output("a_d_ready", bus.d_ready, 32'h1);
    check_output("a_d_rdata", bus.d_rdata, 32'hCAFE_F00D);
    check_output("a_bus_err", bus.bus_err, 32'h0);
    bus.d_req = 1'b0;
    tick();

    // Timeout after four wait cycles with no ack
    apply_stimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_output("t_mem_req_held", bus.mem_req, 32'h1);
      check_output("t_mem_addr_stable", bus.mem_addr, 32'h0000_0100);
      tick();
    end
    check_output("t_mem_req_drop", bus.mem_req, 32'h0);
    check_output("t_i_ready", bus.i_ready, 32'h1);
    check_output("t_i_rdata_zero", bus.i_rdata, 32'h0);
    check_output("t_bus_err", bus.bus_err, 32'h1);
    bus.i_req = 1'b0;
    tick();
    check_output("t_i_ready_pulse", bus.i_ready, 32'h0);
    check_output("t_bus_err_sticky", bus.bus_err, 32'h1);

    // Spurious ack while idle
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_5555;
    tick();
    check_output("s_mem_req", bus.mem_req, 32'h0);
    check_output("s_readies", {bus.i_ready, bus.d_ready}, 32'h0);
    tick();
    check_output("s_readies_2", {bus.i_ready, bus.d_ready}, 32'h0);
    check_output("s_d_rdata_hold", bus.d_rdata, 32'hCAFE_F00D);
    bus.mem_ack = 1'b0;
    tick();

    // Reset in D_WAIT abandons the access; held request is re-granted afterwards
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0060, 32'h0000_0099);
    tick();
    check_output("r_mem_req", bus.mem_req, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check_output("r_mem_req_async", bus.mem_req, 32'h0);
    check_output("r_mem_addr_clr", bus.mem_addr, 32'h0);
    check_output("r_bus_err_clr", bus.bus_err, 32'h0);
    tick();
    check_output("r_no_d_ready", bus.d_ready, 32'h0);
    rst = 1'b1;
    tick();
    check_output("r_regrant_req", bus.mem_req, 32'h1);
    check_output("r_regrant_addr", bus.mem_addr, 32'h0000_0060);
    check_output("r_regrant_we", bus.mem_we, 32'h1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check_output("r_d_ready", bus.d_ready, 32'h1);
    bus.d_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
